mem_access_arbiter: RTL and testbench

// Sequencer/arbiter for the unified multi-cycle memory system (ROM + single-port RAM).

---
 rtl/mem_access_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_access_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
// Shares one multi-cycle memory port between instruction fetch and data load/store.
// One transaction at a time; alternates grants when both sides request.
module mem_access_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req_i,
  input  logic [DATA_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic                  if_err_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [DATA_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic                  d_err_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  localparam logic [2:0] LatLast = 3'(READ_LATENCY);
  localparam bit         NoWait  = (READ_LATENCY == 0);

  logic [1:0]            state_q, state_d;
  logic [2:0]            wait_cnt_q, wait_cnt_d;
  logic                  last_data_q;  // previous grant went to the data port
  logic                  owner_q;      // 1 = data port owns the transaction
  logic                  we_q;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q, rdata_q;

  logic grant_if, grant_d, grant_any, misaligned, capture, resp;

  assign misaligned = (addr_q[1:0] != 2'b00);
  assign resp       = (state_q == StResp);

  // Grants are gated by reset so a request is never acknowledged and then dropped.
  always_comb begin
    grant_d  = 1'b0;
    grant_if = 1'b0;
    if (!reset && state_q == StIdle) begin
      if (d_req_i && (!if_req_i || !last_data_q)) begin
        grant_d = 1'b1;
      end else if (if_req_i) begin
        grant_if = 1'b1;
      end
    end
  end

  assign grant_any = grant_if | grant_d;
  assign capture   = NoWait ? (state_q == StAccess)
                            : (state_q == StWait && wait_cnt_q == LatLast);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      StIdle: begin
        if (grant_any) state_d = StAccess;
      end
      StAccess: begin
        if (NoWait) begin
          state_d = StResp;
        end else begin
          state_d    = StWait;
          wait_cnt_d = 3'd1;
        end
      end
      StWait: begin
        if (wait_cnt_q == LatLast) begin
          state_d = StResp;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wait_cnt_q  <= 3'd0;
      last_data_q <= 1'b0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (grant_any) begin
        owner_q     <= grant_d;
        last_data_q <= grant_d;
        addr_q      <= grant_d ? d_addr_i : if_addr_i;
        we_q        <= grant_d & d_we_i;
        wdata_q     <= grant_d ? d_wdata_i : '0;
      end
      if (capture) begin
        rdata_q <= (we_q || misaligned) ? '0 : mem_rdata_i;
      end
    end
  end

  assign if_gnt_o    = grant_if;
  assign d_gnt_o     = grant_d;
  assign if_rvalid_o = resp & ~owner_q;
  assign d_rvalid_o  = resp & owner_q;
  assign if_err_o    = resp & ~owner_q & misaligned;
  assign d_err_o     = resp & owner_q & misaligned;
  assign rdata_o     = rdata_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_we_o    = (state_q == StAccess) & we_q & ~misaligned;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Randomized bench for mem_access_arbiter against a transaction-level reference model.
// Models the memory (with read latency) and predicts grants, responses and port activity.
module tb_mem_access_arbiter;

  localparam int unsigned READ_LATENCY = 1;
  localparam int LAT      = READ_LATENCY;
  localparam int PIPE_IDX = (LAT == 0) ? 0 : LAT - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt_o, if_rvalid_o, if_err_o, d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i, rd_addr;
  logic        mem_we_o, busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit run     = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_arbiter #(.DATA_WIDTH(32), .READ_LATENCY(READ_LATENCY)) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_gnt_o   (if_gnt_o),
    .if_rvalid_o(if_rvalid_o),
    .if_err_o   (if_err_o),
    .d_req_i    (d_req),
    .d_we_i     (d_we),
    .d_addr_i   (d_addr),
    .d_wdata_i  (d_wdata),
    .d_gnt_o    (d_gnt_o),
    .d_rvalid_o (d_rvalid_o),
    .d_err_o    (d_err_o),
    .rdata_o    (rdata_o),
    .mem_addr_o (mem_addr_o),
    .mem_we_o   (mem_we_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .busy_o     (busy_o)
  );

  function automatic logic [31:0] hash(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Memory: 128 words, read data follows the address by READ_LATENCY cycles.
  logic [31:0] mem_arr [128];
  logic [31:0] apipe   [8];
  bit          mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 128; i++) mem_arr[i] <= hash(i);
      mem_init <= 1'b1;
    end else if (mem_we_o) begin
      mem_arr[mem_addr_o[8:2]] <= mem_wdata_o;
    end
    apipe[0] <= mem_addr_o;
    for (int i = 1; i < 8; i++) apipe[i] <= apipe[i-1];
  end

  assign rd_addr     = (LAT == 0) ? mem_addr_o : apipe[PIPE_IDX];
  assign mem_rdata_i = mem_arr[rd_addr[8:2]];

  // Reference model: one outstanding transaction, fixed timing from its grant cycle.
  logic [31:0] ref_mem [128];
  bit          ref_init = 1'b0;
  bit          last_is_data, txn_valid, txn_owner, txn_we, txn_err;
  logic [31:0] txn_addr, txn_wdata, txn_rdata;
  int          txn_grant, next_free;
  logic        eg_if, eg_d, rv_e, busy_e;
  int          f_cnt = 0;
  int          d_cnt = 0;

  always @(negedge clk) begin
    if (run) begin
      if (!ref_init) begin
        for (int i = 0; i < 128; i++) ref_mem[i] = hash(i);
        ref_init = 1'b1;
      end
      eg_d  = !reset && cyc >= next_free && d_req && (!if_req || !last_is_data);
      eg_if = !reset && cyc >= next_free && if_req && !eg_d;
      check("if_gnt", if_gnt_o, eg_if);
      check("d_gnt", d_gnt_o, eg_d);
      if (if_gnt_o === 1'b1) f_cnt++;
      if (d_gnt_o === 1'b1) d_cnt++;

      rv_e = txn_valid && cyc == txn_grant + 2 + LAT;
      check("if_rvalid", if_rvalid_o, rv_e && !txn_owner);
      check("d_rvalid", d_rvalid_o, rv_e && txn_owner);
      if (rv_e) begin
        check(txn_owner ? "d_err" : "if_err", txn_owner ? d_err_o : if_err_o, txn_err);
        check("rdata", rdata_o, txn_rdata);
      end
      check("mem_we", mem_we_o, txn_valid && txn_we && !txn_err && cyc == txn_grant + 1);

      if (!reset) begin
        busy_e = txn_valid && cyc > txn_grant && cyc <= txn_grant + 2 + LAT;
        check("busy", busy_o, busy_e);
        if (busy_e) begin
          check("mem_addr", mem_addr_o, txn_addr);
          if (txn_owner) check("mem_wdata", mem_wdata_o, txn_wdata);
        end
      end

      if (reset) begin
        txn_valid    = 1'b0;
        last_is_data = 1'b0;
        next_free    = cyc + 1;
      end else if (eg_if || eg_d) begin
        txn_valid = 1'b1;
        txn_owner = eg_d;
        txn_grant = cyc;
        txn_addr  = eg_d ? d_addr : if_addr;
        txn_we    = eg_d && d_we;
        txn_wdata = d_wdata;
        txn_err   = (txn_addr[1:0] != 2'b00);
        txn_rdata = (txn_we || txn_err) ? 32'h0 : ref_mem[txn_addr[8:2]];
        if (txn_we && !txn_err) ref_mem[txn_addr[8:2]] = txn_wdata;
        last_is_data = eg_d;
        next_free    = cyc + 3 + LAT;
      end
    end
  end

  // Requesters drop their request on the edge after they see a grant.
  int f_seen = 0;
  int d_seen = 0;

  task automatic step();
    @(posedge clk);
    #1;
    if (f_cnt != f_seen) begin f_seen = f_cnt; if_req = 1'b0; end
    if (d_cnt != d_seen) begin d_seen = d_cnt; d_req = 1'b0; end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((if_req || d_req) && n < budget) begin step(); n++; end
    check("req_timeout", {31'b0, if_req | d_req}, 32'h0);
    repeat (LAT + 4) step();
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 127)) << 2;
    if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    @(posedge clk); #1;
    run = 1'b1;
    step();
    reset = 1'b0;
    check("rst_busy", busy_o, 1'b0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_mem_we", mem_we_o, 1'b0);
    check("rst_rvalid", {if_rvalid_o, d_rvalid_o}, 2'b00);

    // Fetch from address 0.
    if_addr = 32'h0; if_req = 1'b1;
    drain(20);

    // Store then load back.
    d_we = 1'b1; d_addr = 32'h104; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
    drain(20);
    d_we = 1'b0; d_req = 1'b1;
    drain(20);

    // Both held: data wins first after reset, then strict alternation.
    reset_pulse();
    if_addr = 32'h10; d_we = 1'b0; d_addr = 32'h20;
    if_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int fc, dc;
      fc = f_cnt; dc = d_cnt; n = 0;
      while (f_cnt == fc && d_cnt == dc && n < 20) begin step(); n++; end
      check("alt_order", {31'b0, d_cnt != dc}, (k % 2 == 0) ? 32'h1 : 32'h0);
      if_req = 1'b1; d_req = 1'b1;
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (LAT + 5) step();

    // Misaligned store must not touch the RAM.
    d_we = 1'b1; d_addr = 32'h102; d_wdata = $urandom; d_req = 1'b1;
    drain(20);
    d_we = 1'b0; d_addr = 32'h100; d_req = 1'b1;
    drain(20);

    // Reset while a load is waiting on memory.
    d_we = 1'b0; d_addr = 32'h40; d_req = 1'b1;
    n = 0;
    while (d_req && n < 20) begin step(); n++; end
    repeat ((LAT > 0) ? 1 : 0) step();
    reset_pulse();
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_rvalid", d_rvalid_o, 1'b0);
    check("mid_rst_mem_addr", mem_addr_o, 32'h0);
    check("mid_rst_rdata", rdata_o, 32'h0);
    check("mid_rst_mem_we", mem_we_o, 1'b0);
    repeat (3) step();

    // Random traffic on both ports.
    for (int c = 0; c < 800; c++) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_addr = rand_addr(); if_req = 1'b1;
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_we = 1'($urandom_range(0, 1)); d_addr = rand_addr(); d_wdata = $urandom;
        d_req = 1'b1;
      end
      step();
    end
    drain(60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
